a_buff_reader: RTL and testbench

Read-side sequencer for the A operand buffer. On a start command it issues a run of consecutive reads to the buffer and accounts for the buffer's 1-cycle registered read latency. Returned words are streamed to the PE-row feed logic over a valid/ready interface, with full backpressure and a last-beat marker. It sits between the A buffer and the PE rows and never writes the buffer.

---
 rtl/vit_accel_pkg.sv | 24 ++
 rtl/a_stream_fifo.sv | 51 +++++
 rtl/a_buff_reader.sv | 149 ++++++++++++++
 tb/tb_a_buff_reader.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vit_accel_pkg.sv
// Shared types and helpers for the operand-buffer readers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package vit_accel_pkg;

    localparam int DATA_WIDTH      = 8;
    localparam int MEM_DEPTH       = 8;
    localparam int ADDR_WIDTH      = 3;
    localparam int NUM_MACS        = 2;
    localparam int NUM_PEs_PER_ROW = 4;
    localparam int W               = NUM_PEs_PER_ROW * NUM_MACS * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } reader_state_t;

    // Clamp a requested run length to the number of buffer entries.
    function automatic int sat_len(input int l, input int depth);
        return (l > depth) ? depth : l;
    endfunction

endpackage

// File: rtl/a_stream_fifo.sv
// Two-entry FIFO carrying a data word plus a last-beat flag.
// Latency: push visible at the head the cycle after the push edge.
// Backpressure: caller must not push when full or pop when empty; occ is exported for credit logic.
module a_stream_fifo #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push_last,
    input  logic             pop,
    output logic [1:0]       occ,
    output logic [WIDTH-1:0] head_data,
    output logic             head_last
);

    logic [WIDTH-1:0] data_q [2];
    logic             last_q [2];
    logic             wptr;
    logic             rptr;
    logic [1:0]       cnt;

    // Storage, pointers and occupancy; storage is cleared so the head reads zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                last_q[i] <= 1'b0;
            end
            wptr <= 1'b0;
            rptr <= 1'b0;
            cnt  <= 2'd0;
        end else begin
            if (push) begin
                data_q[wptr] <= push_data;
                last_q[wptr] <= push_last;
                wptr         <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    assign occ       = cnt;
    assign head_data = data_q[rptr];
    assign head_last = last_q[rptr];

endmodule

// File: rtl/a_buff_reader.sv
// Issues a run of consecutive A-buffer reads and streams the returned words to the PE rows.
// Latency: first read in the cycle after start is sampled; first beat two cycles after that.
// Backpressure: full valid/ready; reads are throttled so at most two words are ever outstanding.
module a_buff_reader
    import vit_accel_pkg::*;
#(
    parameter int DATA_WIDTH      = vit_accel_pkg::DATA_WIDTH,
    parameter int MEM_DEPTH       = vit_accel_pkg::MEM_DEPTH,
    parameter int ADDR_WIDTH      = vit_accel_pkg::ADDR_WIDTH,
    parameter int NUM_MACS        = vit_accel_pkg::NUM_MACS,
    parameter int NUM_PEs_PER_ROW = vit_accel_pkg::NUM_PEs_PER_ROW,
    localparam int WW             = NUM_PEs_PER_ROW * NUM_MACS * DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [ADDR_WIDTH-1:0]      base_addr,
    input  logic [ADDR_WIDTH:0]        len,
    output logic                       busy,
    output logic                       done,
    output logic                       buf_en,
    output logic [NUM_PEs_PER_ROW-1:0] buf_wr,
    output logic [ADDR_WIDTH-1:0]      buf_addr,
    input  logic [WW-1:0]              buf_out,
    output logic [WW-1:0]              out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last
);

    localparam logic [ADDR_WIDTH+1:0] DEPTH_W = (ADDR_WIDTH+2)'(MEM_DEPTH);

    reader_state_t         state;
    reader_state_t         state_nxt;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   issued;
    logic [ADDR_WIDTH:0]   len_sat;
    logic [ADDR_WIDTH+1:0] addr_sum;
    logic [2:0]            pend;
    logic                  credit_ok;
    logic                  last_issue;
    logic                  inflight;
    logic                  inflight_last;
    logic                  pop;
    logic                  fin;
    logic                  done_nxt;
    logic [1:0]            occ;
    logic                  head_last;

    assign len_sat    = (ADDR_WIDTH+1)'(sat_len(int'(len), MEM_DEPTH));
    assign pop        = out_valid && out_ready;
    // Words outstanding = FIFO entries plus the read in flight; a pop this edge frees a slot.
    assign pend       = {1'b0, occ} + {2'b0, inflight};
    assign credit_ok  = pend < (3'd2 + {2'b0, pop});
    assign last_issue = (issued == (len_q - 1'b1));
    // Explicit modulo wrap so non-power-of-two depths also work; base and issued are both < depth.
    assign addr_sum   = {2'b0, base_q} + {1'b0, issued};
    assign buf_addr   = (addr_sum >= DEPTH_W) ? ADDR_WIDTH'(addr_sum - DEPTH_W)
                                              : ADDR_WIDTH'(addr_sum);
    // Run is complete once nothing is in flight and the last FIFO entry leaves this edge.
    assign fin        = (state == DRAIN) && !inflight &&
                        ((occ == 2'd0) || ((occ == 2'd1) && pop));

    assign busy      = (state != IDLE);
    assign buf_wr    = '0;
    assign out_valid = (occ != 2'd0);
    assign out_last  = out_valid && head_last;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, read issue and completion strobe.
    always_comb begin
        state_nxt = state;
        buf_en    = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len_sat != '0) begin
                        state_nxt = RUN;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                if ((issued < len_q) && credit_ok) begin
                    buf_en = 1'b1;
                    if (last_issue) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (fin) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Run parameters, issue counter, in-flight tracking and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q        <= '0;
            len_q         <= '0;
            issued        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done          <= 1'b0;
        end else begin
            if ((state == IDLE) && start && (len_sat != '0)) begin
                base_q <= base_addr;
                len_q  <= len_sat;
                issued <= '0;
            end else if (buf_en) begin
                issued <= issued + 1'b1;
            end
            inflight      <= buf_en;
            inflight_last <= buf_en && last_issue;
            done          <= done_nxt;
        end
    end

    a_stream_fifo #(
        .WIDTH (WW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (buf_out),
        .push_last (inflight_last),
        .pop       (pop),
        .occ       (occ),
        .head_data (out_data),
        .head_last (head_last)
    );

endmodule

// File: tb/tb_a_buff_reader.sv
module tb_a_buff_reader;
    import vit_accel_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [2:0]   base_addr;
    logic [3:0]   len;
    logic         busy;
    logic         done;
    logic         buf_en;
    logic [3:0]   buf_wr;
    logic [2:0]   buf_addr;
    logic [W-1:0] buf_out;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;

    logic [W-1:0] mem [8];
    logic [W:0]   exp_q [$];
    logic [2:0]   addr_q [$];

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int beat_cnt = 0;
    int outstanding = 0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;

    always #5 clk = ~clk;

    // Buffer model: registered read, one cycle latency.
    always @(posedge clk) begin
        if (buf_en) buf_out <= mem[buf_addr];
    end

    a_buff_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .buf_en    (buf_en),
        .buf_wr    (buf_wr),
        .buf_addr  (buf_addr),
        .buf_out   (buf_out),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard sampling at the falling edge: addresses, credit rule, stall stability, beats.
    task automatic sample();
        logic [2:0] ea;
        logic [W:0] e;
        int         p;
        @(negedge clk);
        if (rst_n) begin
            p = (out_valid && out_ready) ? 1 : 0;
            if (done) done_cnt++;
            if (buf_en) begin
                checks++;
                if (addr_q.size() == 0) begin
                    failures++;
                    $display("FAIL read_addr got=%0d want=no_read", buf_addr);
                end else begin
                    ea = addr_q.pop_front();
                    if (buf_addr !== ea) begin
                        failures++;
                        $display("FAIL read_addr got=%0d want=%0d", buf_addr, ea);
                    end
                end
                checks++;
                if (outstanding - p >= 2) begin
                    failures++;
                    $display("FAIL read_credit outstanding=%0d pop=%0d want_below=2", outstanding, p);
                end
            end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    failures++;
                    $display("FAIL stall_hold valid=%b data=%h want_valid=1 data=%h",
                             out_valid, out_data, prev_data);
                end
            end
            if (p == 1) begin
                beat_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL beat got=%h want=no_beat", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e[W-1:0] || out_last !== e[W]) begin
                        failures++;
                        $display("FAIL beat got=%h last=%b want=%h last=%b",
                                 out_data, out_last, e[W-1:0], e[W]);
                    end
                end
            end
            outstanding = outstanding + (buf_en ? 1 : 0) - p;
            prev_stall  = out_valid && !out_ready;
            prev_data   = out_data;
        end
    endtask

    task automatic expect_run(input int b, input int l);
        int n;
        int a;
        n = (l > 8) ? 8 : l;
        for (int i = 0; i < n; i++) begin
            a = (b + i) % 8;
            addr_q.push_back(3'(a));
            exp_q.push_back({(i == n - 1), mem[a]});
        end
    endtask

    task automatic launch(input logic [2:0] b, input logic [3:0] l);
        base_addr = b;
        len       = l;
        start     = 1'b1;
        next_edge();
        start     = 1'b0;
    endtask

    // Run cycles from the current one until done; mode 1 toggles ready as 1,0,0,...
    task automatic run_to_done(input int mode, input int budget, output int dcyc);
        dcyc = -1;
        for (int c = 0; c < budget; c++) begin
            out_ready = (mode == 0) ? 1'b1 : ((c % 3) == 0);
            sample();
            if (done) begin
                dcyc = c;
                break;
            end
            next_edge();
        end
        next_edge();
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({busy, done, buf_en, buf_addr, out_valid, out_last} !== 8'd0 || out_data !== '0) begin
            failures++;
            $display("FAIL reset_outputs busy=%b done=%b en=%b addr=%0d vld=%b last=%b data=%h want=all_zero",
                     busy, done, buf_en, buf_addr, out_valid, out_last, out_data);
        end
        checks++;
        if (buf_wr !== 4'd0) begin
            failures++;
            $display("FAIL buf_wr got=%b want=0000", buf_wr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        next_edge();
    endtask

    task automatic test_basic();
        int d0;
        d0 = done_cnt;
        expect_run(0, 2);
        launch(3'd0, 4'd2);
        for (int c = 0; c < 6; c++) begin
            out_ready = 1'b1;
            sample();
            checks++;
            if (buf_en !== (c < 2) || out_valid !== (c == 2 || c == 3) || out_last !== (c == 3) ||
                done !== (c == 4) || busy !== (c < 4)) begin
                failures++;
                $display("FAIL basic_cycle%0d en=%b vld=%b last=%b done=%b busy=%b want=%b%b%b%b%b", c,
                         buf_en, out_valid, out_last, done, busy,
                         c < 2, (c == 2 || c == 3), c == 3, c == 4, c < 4);
            end
            next_edge();
        end
        checks++;
        if (exp_q.size() != 0 || addr_q.size() != 0 || done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL basic_drain beats_left=%0d reads_left=%0d dones=%0d want=0,0,1",
                     exp_q.size(), addr_q.size(), done_cnt - d0);
        end
    endtask

    task automatic test_wrap();
        int d;
        expect_run(6, 4);
        launch(3'd6, 4'd4);
        run_to_done(0, 30, d);
        checks++;
        if (d != 6 || exp_q.size() != 0 || addr_q.size() != 0) begin
            failures++;
            $display("FAIL wrap done_cycle=%0d beats_left=%0d want=6,0", d, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int d;
        int b0;
        b0 = beat_cnt;
        expect_run(3, 8);
        launch(3'd3, 4'd8);
        run_to_done(1, 200, d);
        checks++;
        if (d < 0 || beat_cnt - b0 != 8 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL backpressure done_cycle=%0d beats=%0d left=%0d want=8,0",
                     d, beat_cnt - b0, exp_q.size());
        end
    endtask

    task automatic test_zero_len();
        launch(3'd2, 4'd0);
        sample();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || buf_en !== 1'b0) begin
            failures++;
            $display("FAIL zero_len_c0 done=%b busy=%b en=%b want=1,0,0", done, busy, buf_en);
        end
        next_edge();
        sample();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || buf_en !== 1'b0) begin
            failures++;
            $display("FAIL zero_len_c1 done=%b busy=%b en=%b want=0,0,0", done, busy, buf_en);
        end
        next_edge();
    endtask

    task automatic test_saturate();
        int d;
        int b0;
        b0 = beat_cnt;
        expect_run(5, 15);
        launch(3'd5, 4'd15);
        run_to_done(0, 40, d);
        checks++;
        if (d != 10 || beat_cnt - b0 != 8 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL saturate done_cycle=%0d beats=%0d want=10,8", d, beat_cnt - b0);
        end
    endtask

    task automatic test_start_busy();
        int d;
        int d0;
        d0 = done_cnt;
        expect_run(1, 3);
        launch(3'd1, 4'd3);
        sample();
        next_edge();
        base_addr = 3'd4;
        len       = 4'd5;
        start     = 1'b1;
        sample();
        next_edge();
        start = 1'b0;
        run_to_done(0, 30, d);
        for (int c = 0; c < 4; c++) begin
            sample();
            next_edge();
        end
        checks++;
        if (d != 3 || done_cnt - d0 != 1 || exp_q.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL start_busy done_cycle=%0d dones=%0d left=%0d busy=%b want=3,1,0,0",
                     d, done_cnt - d0, exp_q.size(), busy);
        end
    endtask

    task automatic test_reset_mid();
        int d;
        int d0;
        expect_run(0, 8);
        launch(3'd0, 4'd8);
        for (int c = 0; c < 3; c++) begin
            sample();
            next_edge();
        end
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, buf_en, buf_addr, out_valid, out_last} !== 8'd0 || out_data !== '0) begin
            failures++;
            $display("FAIL reset_mid busy=%b done=%b en=%b addr=%0d vld=%b last=%b data=%h want=all_zero",
                     busy, done, buf_en, buf_addr, out_valid, out_last, out_data);
        end
        exp_q.delete();
        addr_q.delete();
        outstanding = 0;
        prev_stall  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        next_edge();
        for (int c = 0; c < 2; c++) begin
            sample();
            next_edge();
        end
        checks++;
        if (done_cnt != d0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_nodone dones=%0d busy=%b want=0,0", done_cnt - d0, busy);
        end
        expect_run(2, 3);
        launch(3'd2, 4'd3);
        run_to_done(0, 30, d);
        checks++;
        if (d != 5 || exp_q.size() != 0 || addr_q.size() != 0) begin
            failures++;
            $display("FAIL reset_mid_rerun done_cycle=%0d left=%0d want=5,0", d, exp_q.size());
        end
    endtask

    initial begin
        start     = 1'b0;
        base_addr = 3'd0;
        len       = 4'd0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) mem[i] = {$urandom, $urandom};
        mem[0] = 64'h0102030405060708;
        mem[1] = 64'h100F0E0D0C0B0A09;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_saturate();
        test_start_busy();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
